// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result bundle for seq_alu.
//
// Handshake: a transfer on either side happens at a rising clk edge where the
// producer's valid and the consumer's ready are both high. A producer keeps its
// payload stable while valid is high and ready is low. Ready may depend
// combinationally on the opposite side's ready (in_ready follows out_ready
// while a result is being held), but never on the same side's valid.
//
// Signals:
//   in_valid / in_ready         input-side handshake
//   A, B, ALUcode, shamt        operands, opcode, immediate shift amount
//   out_valid / out_ready       output-side handshake
//   result, fzero, fsign,       registered result and flags
//   fcarry, fequal
//
// Modports:
//   master : the upstream/downstream environment (drives operands, out_ready)
//   slave  : the ALU itself
interface seq_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [3:0]         ALUcode;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               fzero;
  logic               fsign;
  logic               fcarry;
  logic               fequal;

  modport master (
    output in_valid, A, B, ALUcode, shamt, out_ready,
    input  in_ready, out_valid, result, fzero, fsign, fcarry, fequal
  );

  modport slave (
    input  in_valid, A, B, ALUcode, shamt, out_ready,
    output in_ready, out_valid, result, fzero, fsign, fcarry, fequal
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready on both sides.
//
// Single-cycle opcodes produce their result one edge after acceptance. MUL
// (ALUcode 0110) runs a shift-add multiplier for WIDTH cycles and returns the
// low WIDTH bits of the unsigned product. A held result can be replaced by a
// new single-cycle result in the same cycle it is consumed, giving one op per
// cycle when the consumer keeps out_ready high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   flush      synchronous abort; drops any in-flight or held operation
//   bus        seq_alu_if.slave (operands, opcode, result, flags, handshakes)
//   state_dbg  current FSM state (0 IDLE, 1 MUL, 2 DONE)
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  seq_alu_if.slave   bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_FWD  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_NEG  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_SLLV = 4'b1000;
  localparam logic [3:0] OP_SRLV = 4'b1010;
  localparam logic [3:0] OP_SRAV = 4'b1011;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  localparam logic [WIDTH:0]     ONE_W    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [SHAMT_W-1:0] LAST_CNT = SHAMT_W'(WIDTH - 1);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  state_t state_q, state_d;

  logic accept;
  logic is_mul;

  // Multiplier state: {hi_q, lo_q} is the running product; lo_q starts as
  // the multiplier and is shifted out LSB first as product bits shift in.
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               eq_q;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;
  logic               mul_last;

  // Single-cycle datapath
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH:0]     wide;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH:0]     sra_w;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_carry;

  // Output register next values
  logic               load_out;
  logic [WIDTH-1:0]   res_d;
  logic               fcarry_d;
  logic               fequal_d;

  logic [WIDTH-1:0]   result_q;
  logic               fzero_q;
  logic               fsign_q;
  logic               fcarry_q;
  logic               fequal_q;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // rst is folded in so in_ready is low for the whole time reset is asserted,
  // and high in the first cycle after release without waiting for an edge.
  assign bus.in_ready  = rst & ~flush &
                         ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready));
  assign bus.out_valid = (state_q == S_DONE);
  assign accept        = bus.in_valid & bus.in_ready;
  assign is_mul        = (bus.ALUcode == OP_MUL);

  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) state_d = is_mul ? S_MUL : S_DONE;
        end
        S_MUL: begin
          if (mul_last) state_d = S_DONE;
        end
        S_DONE: begin
          if (accept) begin
            state_d = is_mul ? S_MUL : S_DONE;
          end else if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shift-add multiplier step
  // ---------------------------------------------------------------------------
  // Add the multiplicand into the high half when the current multiplier bit
  // is set, then shift the whole {carry, hi, lo} right by one.
  always_comb begin
    step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    hi_n     = step_sum[WIDTH:1];
    lo_n     = {step_sum[0], lo_q[WIDTH-1:1]};
  end

  assign mul_last = (state_q == S_MUL) && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
    end else if (accept && is_mul) begin
      mcand_q <= bus.A;
      hi_q    <= '0;
      lo_q    <= bus.B;
      cnt_q   <= '0;
      eq_q    <= (bus.A == bus.B);
    end else if (state_q == S_MUL) begin
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      cnt_q   <= cnt_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-cycle operations
  // ---------------------------------------------------------------------------
  // Immediate shifts have ALUcode[2]=1, variable shifts take the amount from B.
  assign amt = bus.ALUcode[2] ? bus.shamt : bus.B[SHAMT_W-1:0];

  // Each shift is done one bit wider than the operand so the last bit shifted
  // out lands in the extra position; a zero amount leaves a zero there.
  always_comb begin
    shl_w = {1'b0, bus.A} << amt;
    shr_w = {bus.A, 1'b0} >> amt;
    sra_w = $unsigned($signed({bus.A, 1'b0}) >>> amt);
  end

  always_comb begin
    sc_res   = bus.A;
    sc_carry = 1'b0;
    wide     = '0;
    case (bus.ALUcode)
      OP_FWD: begin
        sc_res = bus.A;
      end
      OP_ADD: begin
        wide     = {1'b0, bus.A} + {1'b0, bus.B};
        sc_res   = wide[WIDTH-1:0];
        sc_carry = wide[WIDTH];
      end
      OP_AND: begin
        sc_res = bus.A & bus.B;
      end
      OP_XOR: begin
        sc_res = bus.A ^ bus.B;
      end
      OP_SUB: begin
        // Carry of A + ~B + 1: set when no borrow occurs.
        wide     = {1'b0, bus.A} + {1'b0, ~bus.B} + ONE_W;
        sc_res   = wide[WIDTH-1:0];
        sc_carry = wide[WIDTH];
      end
      OP_NEG: begin
        wide     = {1'b0, ~bus.B} + ONE_W;
        sc_res   = wide[WIDTH-1:0];
        sc_carry = wide[WIDTH];
      end
      OP_SLL, OP_SLLV: begin
        sc_res   = shl_w[WIDTH-1:0];
        sc_carry = shl_w[WIDTH];
      end
      OP_SRL, OP_SRLV: begin
        sc_res   = shr_w[WIDTH:1];
        sc_carry = shr_w[0];
      end
      OP_SRA, OP_SRAV: begin
        sc_res   = sra_w[WIDTH:1];
        sc_carry = sra_w[0];
      end
      default: begin
        sc_res   = bus.A;
        sc_carry = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Loaded either by a single-cycle acceptance or by the final multiply step.
  // Flush suppresses the multiply completion (acceptance is already blocked).
  always_comb begin
    load_out = 1'b0;
    res_d    = sc_res;
    fcarry_d = sc_carry;
    fequal_d = (bus.A == bus.B);
    if (accept && !is_mul) begin
      load_out = 1'b1;
    end else if (mul_last && !flush) begin
      load_out = 1'b1;
      res_d    = lo_n;
      fcarry_d = |hi_n;
      fequal_d = eq_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      fzero_q  <= 1'b0;
      fsign_q  <= 1'b0;
      fcarry_q <= 1'b0;
      fequal_q <= 1'b0;
    end else if (load_out) begin
      result_q <= res_d;
      fzero_q  <= (res_d == '0);
      fsign_q  <= res_d[WIDTH-1];
      fcarry_q <= fcarry_d;
      fequal_q <= fequal_d;
    end
  end

  assign bus.result = result_q;
  assign bus.fzero  = fzero_q;
  assign bus.fsign  = fsign_q;
  assign bus.fcarry = fcarry_q;
  assign bus.fequal = fequal_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random stimulus for seq_alu with a scoreboard.
// Expected {result, fzero, fsign, fcarry, fequal} words are produced by a
// reference function when an input transfer is seen and compared when the
// matching output transfer is seen.
module tb_seq_alu;
  localparam int W  = 32;
  localparam int SW = 5;
  localparam int EW = W + 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  seq_alu #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  bit last_acc = 1'b0;
  bit rand_rdy = 1'b0;

  // Reference model: {result, fzero, fsign, fcarry, fequal}
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] code, input logic [SW-1:0] sh);
    logic [W-1:0]   r;
    logic           c;
    logic [2*W-1:0] p;
    int             n;
    r = a;
    c = 1'b0;
    n = code[2] ? int'(sh) : int'(b[SW-1:0]);
    case (code)
      4'b0001: begin p = {32'b0, a} + {32'b0, b};        r = p[W-1:0]; c = p[W]; end
      4'b0010: r = a & b;
      4'b0011: r = a ^ b;
      4'b0100: begin p = {32'b0, a} + {32'b0, ~b} + 64'd1; r = p[W-1:0]; c = p[W]; end
      4'b0101: begin p = {32'b0, ~b} + 64'd1;            r = p[W-1:0]; c = p[W]; end
      4'b0110: begin p = {32'b0, a} * {32'b0, b};        r = p[W-1:0]; c = |p[2*W-1:W]; end
      4'b1000, 4'b1100: begin r = a << n; c = (n == 0) ? 1'b0 : a[W-n]; end
      4'b1010, 4'b1110: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
      4'b1011, 4'b1111: begin r = $signed(a) >>> n; c = (n == 0) ? 1'b0 : a[n-1]; end
      default: begin r = a; c = 1'b0; end
    endcase
    return {r, (r == '0), r[W-1], c, (a == b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at the following negedge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    logic [EW-1:0] e;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    last_acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_pop++;
        chk("result_flags", 64'({bus.result, bus.fzero, bus.fsign, bus.fcarry, bus.fequal}), 64'(e));
      end
    end
    if (last_acc) exp_q.push_back(model(bus.A, bus.B, bus.ALUcode, bus.shamt));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [3:0] code, input logic [SW-1:0] sh);
    int guard;
    bus.A        = a;
    bus.B        = b;
    bus.ALUcode  = code;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    guard = 0;
    tick();
    while (!last_acc && guard < 100) begin
      tick();
      guard++;
    end
    chk("accept", 64'(last_acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n0;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALUcode   = 4'b0000;
    bus.shamt     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_result_flags", 64'({bus.result, bus.fzero, bus.fsign, bus.fcarry, bus.fequal}), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);

    // Add with latency 1
    bus.out_ready = 1'b1;
    op(32'd12, 32'd11, 4'b0001, '0);
    chk("add_latency", 64'(bus.out_valid), 64'd1);
    chk("add_result", 64'(bus.result), 64'd23);
    drain();

    // Subtract / flags
    op(32'd172, 32'd124, 4'b0100, '0);
    drain();
    op(32'd5, 32'd5, 4'b0100, '0);
    drain();

    // Shifts back to back, one result per cycle
    n0 = n_pop;
    op(32'h8000_0000, 32'd2, 4'b1011, '0);
    op(32'h8000_0000, 32'd2, 4'b1010, '0);
    op(32'd4, 32'd0, 4'b1100, 5'd2);
    op(32'hF0F0_1234, 32'd0, 4'b1111, 5'd0);
    op(32'h0000_00FF, 32'd31, 4'b1000, '0);
    tick();
    chk("shift_throughput", 64'(n_pop - n0), 64'd5);
    drain();

    // MUL 7*9: busy for WIDTH cycles, valid after edge k+WIDTH
    op(32'd7, 32'd9, 4'b0110, '0);
    for (int j = 0; j < W; j++) begin
      chk("mul_busy", 64'({bus.in_ready, bus.out_valid}), 64'd0);
      tick();
    end
    chk("mul_done_valid", 64'(bus.out_valid), 64'd1);
    chk("mul_result", 64'(bus.result), 64'd63);
    drain();

    // MUL overflow
    op(32'h0001_0000, 32'h0001_0000, 4'b0110, '0);
    drain();

    // Backpressure: hold result with out_ready low, offered input refused
    bus.out_ready = 1'b0;
    op(32'd12, 32'd11, 4'b0001, '0);
    bus.A = 32'd1; bus.B = 32'd1; bus.ALUcode = 4'b0001; bus.in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("stall_hold", 64'({bus.result, bus.fzero, bus.fsign, bus.fcarry, bus.fequal}), 64'(exp_q[0]));
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n0 = n_pop;
    op(32'd1, 32'd2, 4'b0001, '0);
    op(32'd3, 32'd5, 4'b0011, '0);
    op(32'hFFFF_FFFF, 32'd1, 4'b0001, '0);
    chk("b2b_throughput", 64'(n_pop - n0), 64'd3);
    drain();

    // Flush mid-MUL, simultaneous in_valid refused
    op(32'd99, 32'd77, 4'b0110, '0);
    repeat (9) tick();
    flush = 1'b1;
    bus.A = 32'd1; bus.B = 32'd2; bus.ALUcode = 4'b0001; bus.in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_state", 64'(state_dbg), 64'd0);
    op(32'd3, 32'd4, 4'b0001, '0);
    drain();

    // Reset mid-MUL
    op(32'd123, 32'd45, 4'b0110, '0);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    chk("rst_mul_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mul_state", 64'(state_dbg), 64'd0);
    chk("rst_mul_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_mul_result", 64'(bus.result), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    op(32'd3, 32'd4, 4'b0001, '0);
    drain();

    // Random mix with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op($urandom, $urandom, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
